// File: rtl/artipattern_gen.sv
// artipattern_gen: test-pattern video source (solid grey, hi-res stripes of both phases, bars).
// Optional feature macro: ARTIPATTERN_SCROLL_EN (per-frame horizontal scroll of the bar chart).
module artipattern_gen #(
    parameter int unsigned H_ACTIVE     = 320,
    parameter int unsigned H_TOTAL      = 400,
    parameter int unsigned HS_START     = 336,
    parameter int unsigned HS_LEN       = 32,
    parameter int unsigned V_ACTIVE     = 240,
    parameter int unsigned V_TOTAL_NTSC = 262,
    parameter int unsigned V_TOTAL_PAL  = 312,
    parameter int unsigned VS_START     = 248,
    parameter int unsigned VS_LEN       = 3,
    parameter int unsigned BAND_W       = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       pal,
    input  logic [1:0] mode,
    input  logic [3:0] lum,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic       hbl_out,
    output logic       vbl_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       frame_start
);

    localparam int unsigned VMax = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
    localparam int unsigned HW   = $clog2(H_TOTAL);
    localparam int unsigned VW   = $clog2(VMax + 1);
    localparam int unsigned XW   = $clog2(H_ACTIVE);
    localparam int unsigned IW   = $clog2(BAND_W);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [VW-1:0] vtot_q, vtot_d;
    logic [1:0]    mode_l_q, mode_l_d;
    logic [3:0]    lum_l_q, lum_l_d;
    // Scrolled column hx, tracked as band / in-band position instead of dividing by BAND_W
    logic [XW-1:0] hx_q, hx_d;
    logic [2:0]    band_q, band_d;
    logic [IW-1:0] inb_q, inb_d;
    logic [7:0]    pix_q, pix_d;
    logic          hbl_q, hbl_d, vbl_q, vbl_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

    // Values loaded into the column counters at the start of each line
    logic [XW-1:0] hx0, hx0_inc;
    logic [2:0]    band0, band0_inc;
    logic [IW-1:0] inb0, inb0_inc;

`ifdef ARTIPATTERN_SCROLL_EN
    logic [XW-1:0] s_q, s_d;
    logic [2:0]    s_band_q, s_band_d;
    logic [IW-1:0] s_inb_q, s_inb_d;
    // Lines use the latched offset; the line that opens a new frame already uses the bumped one
    always_comb begin
        hx0   = s_q;
        band0 = s_band_q;
        inb0  = s_inb_q;
        if (32'(s_q) == H_ACTIVE - 1) begin
            hx0_inc   = '0;
            band0_inc = '0;
            inb0_inc  = '0;
        end else if (32'(s_inb_q) == BAND_W - 1) begin
            hx0_inc   = s_q + 1'b1;
            band0_inc = s_band_q + 1'b1;
            inb0_inc  = '0;
        end else begin
            hx0_inc   = s_q + 1'b1;
            band0_inc = s_band_q;
            inb0_inc  = s_inb_q + 1'b1;
        end
    end
`else
    // Static bars: every line starts at column 0
    always_comb begin
        hx0       = '0;
        band0     = '0;
        inb0      = '0;
        hx0_inc   = '0;
        band0_inc = '0;
        inb0_inc  = '0;
    end
`endif

    logic       first, line_end, frame_end;
    logic [1:0] mode_e;
    logic [7:0] g;

    // Next-state for counters, frame latches and registered outputs
    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        vtot_d   = vtot_q;
        mode_l_d = mode_l_q;
        lum_l_d  = lum_l_q;
        hx_d     = hx_q;
        band_d   = band_q;
        inb_d    = inb_q;
        pix_d    = pix_q;
        hbl_d    = hbl_q;
        vbl_d    = vbl_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        fs_d     = fs_q;
`ifdef ARTIPATTERN_SCROLL_EN
        s_d      = s_q;
        s_band_d = s_band_q;
        s_inb_d  = s_inb_q;
`endif
        first     = (h_q == '0) && (v_q == '0);
        line_end  = (32'(h_q) == H_TOTAL - 1);
        frame_end = line_end && (32'(v_q) == 32'(vtot_q) - 1);
        // Pixel (0,0) belongs to the new frame, so it sees the values being latched
        mode_e    = first ? mode : mode_l_q;
        g         = first ? {lum, lum} : {lum_l_q, lum_l_q};

        if (ce_pix) begin
            if (first) begin
                mode_l_d = mode;
                lum_l_d  = lum;
                vtot_d   = pal ? VW'(V_TOTAL_PAL) : VW'(V_TOTAL_NTSC);
`ifdef ARTIPATTERN_SCROLL_EN
                s_d      = hx0_inc;
                s_band_d = band0_inc;
                s_inb_d  = inb0_inc;
`endif
            end

            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end

            if (frame_end) begin
                hx_d   = hx0_inc;
                band_d = band0_inc;
                inb_d  = inb0_inc;
            end else if (line_end) begin
                hx_d   = hx0;
                band_d = band0;
                inb_d  = inb0;
            end else begin
                hx_d = (32'(hx_q) == H_ACTIVE - 1) ? '0 : hx_q + 1'b1;
                if (32'(inb_q) == BAND_W - 1) begin
                    inb_d  = '0;
                    band_d = band_q + 1'b1;
                end else begin
                    inb_d = inb_q + 1'b1;
                end
            end

            hbl_d = 32'(h_q) >= H_ACTIVE;
            vbl_d = 32'(v_q) >= V_ACTIVE;
            hs_d  = (32'(h_q) >= HS_START) && (32'(h_q) < HS_START + HS_LEN);
            vs_d  = (32'(v_q) >= VS_START) && (32'(v_q) < VS_START + VS_LEN);
            fs_d  = first;

            unique case (mode_e)
                2'd0: pix_d = g;
                2'd1: pix_d = h_q[0] ? 8'h00 : g;
                2'd2: pix_d = h_q[0] ? g : 8'h00;
                default: begin
                    unique case (band_q)
                        3'd0, 3'd4: pix_d = g;
                        3'd1, 3'd5: pix_d = hx_q[0] ? 8'h00 : g;
                        3'd2, 3'd6: pix_d = hx_q[0] ? g : 8'h00;
                        3'd3:       pix_d = 8'h00;
                        default:    pix_d = 8'hFF;
                    endcase
                end
            endcase
            if (hbl_d || vbl_d) begin
                pix_d = 8'h00;
            end
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            vtot_q   <= VW'(V_TOTAL_NTSC);
            mode_l_q <= '0;
            lum_l_q  <= '0;
`ifdef ARTIPATTERN_SCROLL_EN
            // Frame 0 line 0 already uses the offset produced by the first latch (0 -> 1)
            hx_q     <= XW'(1);
            band_q   <= '0;
            inb_q    <= IW'(1);
            s_q      <= '0;
            s_band_q <= '0;
            s_inb_q  <= '0;
`else
            hx_q     <= '0;
            band_q   <= '0;
            inb_q    <= '0;
`endif
            pix_q    <= '0;
            hbl_q    <= 1'b0;
            vbl_q    <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            vtot_q   <= vtot_d;
            mode_l_q <= mode_l_d;
            lum_l_q  <= lum_l_d;
            hx_q     <= hx_d;
            band_q   <= band_d;
            inb_q    <= inb_d;
`ifdef ARTIPATTERN_SCROLL_EN
            s_q      <= s_d;
            s_band_q <= s_band_d;
            s_inb_q  <= s_inb_d;
`endif
            pix_q    <= pix_d;
            hbl_q    <= hbl_d;
            vbl_q    <= vbl_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
        end
    end

    assign r_out       = pix_q;
    assign g_out       = pix_q;
    assign b_out       = pix_q;
    assign hbl_out     = hbl_q;
    assign vbl_out     = vbl_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_artipattern_gen.sv
// Testbench for artipattern_gen (default build, scroll disabled). Short frames keep runtime low.
module tb_artipattern_gen;

    localparam int HA  = 320;
    localparam int HT  = 400;
    localparam int HSS = 336;
    localparam int HSL = 32;
    localparam int VA  = 12;
    localparam int VTN = 20;
    localparam int VTP = 24;
    localparam int VSS = 14;
    localparam int VSL = 3;
    localparam int BW  = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic       pal = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] lum = 4'd0;
    logic [7:0] r_out, g_out, b_out;
    logic       hbl_out, vbl_out, hs_out, vs_out, frame_start;

    artipattern_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_LEN(HSL),
        .V_ACTIVE(VA), .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP),
        .VS_START(VSS), .VS_LEN(VSL), .BAND_W(BW)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .pal(pal), .mode(mode), .lum(lum),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hbl_out(hbl_out), .vbl_out(vbl_out), .hs_out(hs_out), .vs_out(vs_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [28:0] sb[$];
    int mh, mv, mmode, mlum, mvtot;

    function automatic logic [7:0] exp_pix(int h, int v, int md, int lm);
        logic [7:0] g;
        int b;
        g = 8'(lm * 17);
        if (h >= HA || v >= VA) return 8'h00;
        case (md)
            0: return g;
            1: return (h % 2 == 0) ? g : 8'h00;
            2: return (h % 2 == 1) ? g : 8'h00;
            default: begin
                b = h / BW;
                case (b)
                    0, 4: return g;
                    1, 5: return (h % 2 == 0) ? g : 8'h00;
                    2, 6: return (h % 2 == 1) ? g : 8'h00;
                    3: return 8'h00;
                    default: return 8'hFF;
                endcase
            end
        endcase
    endfunction

    task automatic model_reset;
        mh = 0; mv = 0; mmode = 0; mlum = 0; mvtot = VTN;
        sb.delete();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ce_pix = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock; with ce the model predicts the output and queues it for the monitor
    task automatic tick(input logic ce);
        logic [7:0] p;
        logic f;
        @(negedge clk);
        ce_pix = ce;
        if (ce) begin
            f = (mh == 0 && mv == 0);
            if (f) begin
                mmode = mode; mlum = lum; mvtot = pal ? VTP : VTN;
            end
            p = exp_pix(mh, mv, mmode, mlum);
            sb.push_back({p, p, p, mh >= HA, mv >= VA, (mh >= HSS && mh < HSS + HSL),
                          (mv >= VSS && mv < VSS + VSL), f});
            mh++;
            if (mh == HT) begin
                mh = 0; mv++;
                if (mv == mvtot) mv = 0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops on enabled cycles, requires held outputs otherwise
    logic        mon_ce, mon_rst;
    logic [28:0] obs, prev_obs, exp_v;
    initial prev_obs = '0;
    always @(posedge clk) begin
        mon_ce = ce_pix;
        mon_rst = reset;
        #1;
        obs = {r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out, frame_start};
        if (!mon_rst && !reset) begin
            if (mon_ce) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty obs=%h", obs);
                end else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL scoreboard t=%0t obs=%h exp=%h", $time, obs, exp_v);
                    end
                end
            end else begin
                checks++;
                if (obs !== prev_obs) begin
                    errors++;
                    $display("FAIL hold_when_ce_low t=%0t obs=%h exp=%h", $time, obs, prev_obs);
                end
            end
            prev_obs = obs;
        end else begin
            prev_obs = '0;
        end
    end

    task automatic test_reset;
        pal = 1'b0; mode = 2'd0; lum = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out, frame_start} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {r_out, g_out, b_out, hbl_out});
        end
        do_reset();
        tick(1'b1);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_start got=%b exp=1", frame_start);
        end
        checks++;
        if ({r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out} !== 28'd0) begin
            errors++;
            $display("FAIL first_pixel_zero got=%h exp=0", {r_out, hbl_out, vbl_out, hs_out});
        end
        tick(1'b1);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_single got=%b exp=0", frame_start);
        end
    endtask

    task automatic test_ntsc_timing;
        int rise1, rise2, fs2;
        logic prev_hs;
        rise1 = 0; rise2 = 0; fs2 = 0; prev_hs = 1'b0;
        pal = 1'b0; mode = 2'd0; lum = 4'd3;
        do_reset();
        for (int n = 1; n <= 8001; n++) begin
            tick(1'b1);
            if (hs_out && !prev_hs) begin
                if (rise1 == 0) rise1 = n;
                else if (rise2 == 0) rise2 = n;
            end
            prev_hs = hs_out;
            if (frame_start && n > 1 && fs2 == 0) fs2 = n;
        end
        checks++;
        if (rise1 != 337) begin
            errors++;
            $display("FAIL hs_first_rise got=%0d exp=337", rise1);
        end
        checks++;
        if (rise2 - rise1 != HT) begin
            errors++;
            $display("FAIL hs_period got=%0d exp=%0d", rise2 - rise1, HT);
        end
        checks++;
        if (fs2 - 1 != HT * VTN) begin
            errors++;
            $display("FAIL ntsc_frame_period got=%0d exp=%0d", fs2 - 1, HT * VTN);
        end
    endtask

    task automatic test_pal;
        int fs[4];
        int nfs, vs_cnt, vs_first;
        nfs = 0; vs_cnt = 0; vs_first = 0;
        for (int i = 0; i < 4; i++) fs[i] = 0;
        pal = 1'b1; mode = 2'd0; lum = 4'd9;
        do_reset();
        for (int n = 1; n <= 27201; n++) begin
            if (n == 9601 + 2000) pal = 1'b0;
            tick(1'b1);
            if (frame_start && nfs < 4) begin
                fs[nfs] = n; nfs++;
            end
            if (n <= HT * VTP && vs_out) begin
                vs_cnt++;
                if (vs_first == 0) vs_first = n;
            end
        end
        checks++;
        if (fs[1] - fs[0] != HT * VTP) begin
            errors++;
            $display("FAIL pal_frame_period got=%0d exp=%0d", fs[1] - fs[0], HT * VTP);
        end
        checks++;
        if (fs[2] - fs[1] != HT * VTP) begin
            errors++;
            $display("FAIL pal_toggle_frame got=%0d exp=%0d", fs[2] - fs[1], HT * VTP);
        end
        checks++;
        if (fs[3] - fs[2] != HT * VTN) begin
            errors++;
            $display("FAIL ntsc_after_toggle got=%0d exp=%0d", fs[3] - fs[2], HT * VTN);
        end
        checks++;
        if (vs_cnt != VSL * HT || vs_first != VSS * HT + 1) begin
            errors++;
            $display("FAIL vs_window got=%0d/%0d exp=%0d/%0d", vs_cnt, vs_first, VSL * HT,
                     VSS * HT + 1);
        end
    endtask

    task automatic test_stripes_mode_change;
        logic [7:0] got[6];
        logic [7:0] want[6];
        int at[6];
        at = '{1, 2, 321, VA * HT + 1, 8001, 8002};
        want = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA};
        pal = 1'b0; mode = 2'd1; lum = 4'hA;
        do_reset();
        for (int n = 1; n <= 8002; n++) begin
            if (n == 5 * HT + 1) mode = 2'd2;
            tick(1'b1);
            for (int k = 0; k < 6; k++) if (n == at[k]) got[k] = r_out;
            if (n == 1) begin
                checks++;
                if (g_out !== r_out || b_out !== r_out) begin
                    errors++;
                    $display("FAIL rgb_equal got=%h/%h/%h", r_out, g_out, b_out);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got[k] !== want[k]) begin
                errors++;
                $display("FAIL stripe_sample_%0d got=%h exp=%h", k, got[k], want[k]);
            end
        end
    endtask

    task automatic test_bars;
        logic [7:0] bar[HT];
        int idx[9];
        logic [7:0] want[9];
        idx = '{0, 39, 40, 41, 120, 159, 280, 319, 320};
        want = '{8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        pal = 1'b0; mode = 2'd3; lum = 4'd5;
        do_reset();
        for (int n = 1; n <= HT; n++) begin
            tick(1'b1);
            bar[n - 1] = r_out;
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (bar[idx[k]] !== want[k]) begin
                errors++;
                $display("FAIL bar_px%0d got=%h exp=%h", idx[k], bar[idx[k]], want[k]);
            end
        end
    endtask

    task automatic test_ce_gating_reset;
        pal = 1'b0; mode = 2'd0; lum = 4'd7;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
        end
        checks++;
        if (r_out !== 8'h77) begin
            errors++;
            $display("FAIL gated_pixel got=%h exp=77", r_out);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out, frame_start} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset_clear got=%h exp=0", {r_out, hbl_out, frame_start});
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick(1'b1);
        checks++;
        if (frame_start !== 1'b1 || r_out !== 8'h77) begin
            errors++;
            $display("FAIL restart_after_reset got=%b/%h exp=1/77", frame_start, r_out);
        end
    endtask

    initial begin
        test_reset();
        test_ntsc_timing();
        test_pal();
        test_stripes_mode_change();
        test_bars();
        test_ce_gating_reset();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
